// File: rtl/lns_mem_arbiter.sv
// lns_mem_arbiter
//
// Shares one single-port memory between the instruction-fetch requester (F)
// and the data load/store requester (D). At most one request is granted per
// cycle, and the grant is combinational (same-cycle accept). D normally wins.
// A streak counter forces F through after D_BURST_MAX consecutive D grants
// while F waits. A LOCK state keeps the memory for D across an atomic
// read-modify-write sequence. Every granted read is tagged so that its
// data, returning MEM_LAT cycles later, is steered to the right requester.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   f_req/f_addr               fetch request and address
//   f_gnt/f_rvalid/f_rdata     fetch accept, read-return valid, read data
//   d_req/d_we/d_lock          data request, write enable, lock request
//   d_addr/d_wdata             data address and write data
//   d_gnt/d_rvalid/d_rdata     data accept, read-return valid, read data
//   mem_en/mem_we              memory command valid and write enable
//   mem_addr/mem_wdata         memory address and write data
//   mem_rdata                  memory read data (valid MEM_LAT cycles after a read)
//   locked                     arbiter is holding the memory for D

module lns_mem_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int MEM_LAT     = 1,
  parameter int D_BURST_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          locked
);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(D_BURST_MAX);

  state_t             r_state;
  logic [3:0]         r_streak;
  logic [MEM_LAT-1:0] r_vld;
  logic [MEM_LAT-1:0] r_tagD;

  logic w_lockHold;
  logic w_streakFull;
  logic w_fGnt;
  logic w_dGnt;
  logic w_retValid;
  logic w_retTagD;

  // Winner selection. While locked (and D still asserts d_lock) only D can
  // be served. The cycle d_lock drops already uses the normal ARB rules.
  always_comb begin
    w_lockHold   = (r_state == ST_LOCK) && d_lock;
    w_streakFull = (r_streak == BURST_MAX);
    w_fGnt       = 1'b0;
    w_dGnt       = 1'b0;
    if (w_lockHold) begin
      w_dGnt = d_req;
    end else if (d_req && !(f_req && w_streakFull)) begin
      w_dGnt = 1'b1;
    end else begin
      w_fGnt = f_req;
    end
  end

  // FSM, streak counter and read-tag pipeline. The streak only counts D
  // grants that made F wait, and it is frozen for the whole lock period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_ARB;
      r_streak <= 4'd0;
      r_vld    <= '0;
      r_tagD   <= '0;
    end else begin
      if (w_lockHold) begin
        r_state <= ST_LOCK;
      end else if (w_dGnt && d_lock) begin
        r_state <= ST_LOCK;
      end else begin
        r_state <= ST_ARB;
      end

      if (!w_lockHold) begin
        if (w_fGnt || !f_req) begin
          r_streak <= 4'd0;
        end else if (w_dGnt && !w_streakFull) begin
          r_streak <= r_streak + 4'd1;
        end
      end

      r_vld[0]  <= w_fGnt || (w_dGnt && !d_we);
      r_tagD[0] <= w_dGnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_tagD[i] <= r_tagD[i-1];
      end
    end
  end

  assign w_retValid = r_vld[MEM_LAT-1];
  assign w_retTagD  = r_tagD[MEM_LAT-1];

  // Everything is forced to zero while reset is held, including the
  // combinational grant path and any read still in flight.
  assign f_gnt     = reset & w_fGnt;
  assign d_gnt     = reset & w_dGnt;
  assign mem_en    = reset & (w_fGnt | w_dGnt);
  assign mem_we    = reset & w_dGnt & d_we;
  assign mem_addr  = !reset ? '0 : (w_dGnt ? d_addr : (w_fGnt ? f_addr : '0));
  assign mem_wdata = (reset && w_dGnt) ? d_wdata : '0;
  assign locked    = reset & (r_state == ST_LOCK);

  assign f_rvalid = reset & w_retValid & ~w_retTagD;
  assign d_rvalid = reset & w_retValid & w_retTagD;
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_lns_mem_arbiter.sv
// tb_lns_mem_arbiter
//
// Directed bench for lns_mem_arbiter. Two instances share every input:
// dutA uses MEM_LAT=1 and dutB uses MEM_LAT=3, and both use D_BURST_MAX=3.
// The bench drives mem_rdata directly in the cycle a return is due, so the
// expected read data is known exactly. Inputs change 1 time unit after each
// rising edge, and outputs are sampled 1 time unit later.

module tb_lns_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_we, d_lock;
  logic [15:0] f_addr, d_addr, d_wdata, mem_rdata;

  logic        a_f_gnt, a_f_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_locked;
  logic [15:0] a_f_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic        b_f_gnt, b_f_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_locked;
  logic [15:0] b_f_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  lns_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .D_BURST_MAX(3)) dutA (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(a_f_gnt), .f_rvalid(a_f_rvalid), .f_rdata(a_f_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata), .locked(a_locked)
  );

  lns_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .D_BURST_MAX(3)) dutB (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(b_f_gnt), .f_rvalid(b_f_rvalid), .f_rdata(b_f_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata), .locked(b_locked)
  );

  // Advance to just after the next rising edge, where new inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with no requests, used to flush both return pipelines.
  task automatic idle(input int n);
    repeat (n) begin
      tick();
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0;
      f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    end
  endtask

  // Reset is held with both requests active, and every output must still be zero.
  task automatic test_reset();
    reset = 1'b0;
    f_req = 1'b1; f_addr = 16'h0077;
    d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 16'h0055; d_wdata = 16'hAAAA;
    mem_rdata = 16'h1234;
    tick();
    tick();
    #1;
    nCompared++;
    if ({a_f_gnt, a_f_rvalid, a_f_rdata, a_d_gnt, a_d_rvalid, a_d_rdata, a_mem_en, a_mem_we,
         a_mem_addr, a_mem_wdata, a_locked} !== 71'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs_A: got gnt f%b d%b en %b addr %h wdata %h locked %b, want all 0",
               a_f_gnt, a_d_gnt, a_mem_en, a_mem_addr, a_mem_wdata, a_locked);
    end
    nCompared++;
    if ({b_f_gnt, b_f_rvalid, b_f_rdata, b_d_gnt, b_d_rvalid, b_d_rdata, b_mem_en, b_mem_we,
         b_mem_addr, b_mem_wdata, b_locked} !== 71'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs_B: got gnt f%b d%b en %b addr %h wdata %h locked %b, want all 0",
               b_f_gnt, b_d_gnt, b_mem_en, b_mem_addr, b_mem_wdata, b_locked);
    end
  endtask

  // A single fetch read right after reset release returns one cycle later.
  task automatic test_fetch_read();
    tick();
    reset = 1'b1;
    f_req = 1'b1; f_addr = 16'h0010;
    d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    #1;
    nCompared++;
    if ({a_f_gnt, a_d_gnt, a_mem_en, a_mem_we} !== 4'b1010) begin
      nMismatched++;
      $display("[TB] FAIL fetch_grant: got f_gnt %b d_gnt %b en %b we %b, want 1 0 1 0",
               a_f_gnt, a_d_gnt, a_mem_en, a_mem_we);
    end
    nCompared++;
    if (a_mem_addr !== 16'h0010) begin
      nMismatched++;
      $display("[TB] FAIL fetch_addr: got %h want 0010", a_mem_addr);
    end
    tick();
    f_req = 1'b0;
    mem_rdata = 16'h2339;
    #1;
    nCompared++;
    if ({a_f_rvalid, a_d_rvalid} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL fetch_rvalid: got f %b d %b want f 1 d 0", a_f_rvalid, a_d_rvalid);
    end
    nCompared++;
    if (a_f_rdata !== 16'h2339) begin
      nMismatched++;
      $display("[TB] FAIL fetch_rdata: got %h want 2339", a_f_rdata);
    end
  endtask

  // Both requesters read continuously. The expected grant order is D,D,D,F,
  // and each cycle returns the previous cycle's read on dutA.
  task automatic test_back_to_back();
    logic expD, prevD, prevAny;
    logic [15:0] expData;
    for (int i = 0; i < 8; i++) begin
      tick();
      f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_lock = 1'b0;
      f_addr = 16'(16'h0100 + i); d_addr = 16'(16'h0200 + i);
      mem_rdata = 16'(16'hA000 + i);
      #1;
      expD    = ((i % 4) != 3);
      prevAny = (i > 0);
      prevD   = (i > 0) && (((i - 1) % 4) != 3);
      nCompared++;
      if ({a_d_gnt, a_f_gnt} !== {expD, ~expD}) begin
        nMismatched++;
        $display("[TB] FAIL burst_grant[%0d]: got d %b f %b want d %b f %b",
                 i, a_d_gnt, a_f_gnt, expD, ~expD);
      end
      nCompared++;
      if (a_mem_addr !== (expD ? 16'(16'h0200 + i) : 16'(16'h0100 + i))) begin
        nMismatched++;
        $display("[TB] FAIL burst_addr[%0d]: got %h", i, a_mem_addr);
      end
      nCompared++;
      if ({a_d_rvalid, a_f_rvalid} !== {prevAny & prevD, prevAny & ~prevD}) begin
        nMismatched++;
        $display("[TB] FAIL burst_rvalid[%0d]: got d %b f %b want d %b f %b",
                 i, a_d_rvalid, a_f_rvalid, prevAny & prevD, prevAny & ~prevD);
      end
      expData = (prevAny && prevD) ? 16'(16'hA000 + i) : 16'h0000;
      nCompared++;
      if (a_d_rdata !== expData) begin
        nMismatched++;
        $display("[TB] FAIL burst_d_rdata[%0d]: got %h want %h", i, a_d_rdata, expData);
      end
    end
  endtask

  // A D write wins over F and must never produce a read return on either instance.
  task automatic test_write();
    idle(3);
    tick();
    f_req = 1'b1; f_addr = 16'h0040;
    d_req = 1'b1; d_we = 1'b1; d_lock = 1'b0; d_addr = 16'h0020; d_wdata = 16'hBEEF;
    #1;
    nCompared++;
    if ({a_d_gnt, a_f_gnt, a_mem_en, a_mem_we} !== 4'b1011) begin
      nMismatched++;
      $display("[TB] FAIL write_grant: got d %b f %b en %b we %b want 1 0 1 1",
               a_d_gnt, a_f_gnt, a_mem_en, a_mem_we);
    end
    nCompared++;
    if ({a_mem_addr, a_mem_wdata} !== {16'h0020, 16'hBEEF}) begin
      nMismatched++;
      $display("[TB] FAIL write_cmd: got addr %h wdata %h want 0020 beef", a_mem_addr, a_mem_wdata);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      mem_rdata = 16'h5A5A;
      #1;
      nCompared++;
      if ({a_d_rvalid, a_f_rvalid, b_d_rvalid, b_f_rvalid} !== 4'b0000) begin
        nMismatched++;
        $display("[TB] FAIL write_no_rvalid[+%0d]: got A d %b f %b B d %b f %b want all 0",
                 k, a_d_rvalid, a_f_rvalid, b_d_rvalid, b_f_rvalid);
      end
    end
  endtask

  // A locked D sequence holds F off well past D_BURST_MAX. F gets through
  // in the same cycle d_lock drops.
  task automatic test_lock();
    idle(1);
    tick();
    f_req = 1'b1; f_addr = 16'h0050;
    d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_addr = 16'h0030;
    #1;
    nCompared++;
    if ({a_d_gnt, a_f_gnt, a_locked} !== 3'b100) begin
      nMismatched++;
      $display("[TB] FAIL lock_enter: got d %b f %b locked %b want 1 0 0", a_d_gnt, a_f_gnt, a_locked);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      nCompared++;
      if ({a_locked, a_f_gnt, a_d_gnt} !== 3'b101) begin
        nMismatched++;
        $display("[TB] FAIL lock_hold[%0d]: got locked %b f %b d %b want 1 0 1",
                 k, a_locked, a_f_gnt, a_d_gnt);
      end
    end
    tick();
    d_lock = 1'b0; d_req = 1'b0;
    #1;
    nCompared++;
    if ({a_f_gnt, a_d_gnt} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL lock_release_grant: got f %b d %b want f 1 d 0", a_f_gnt, a_d_gnt);
    end
    tick();
    f_req = 1'b0;
    #1;
    nCompared++;
    if (a_locked !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL lock_exit: got locked %b want 0", a_locked);
    end
  endtask

  // The streak is built to 3 and a locked read is issued, then reset is
  // pulsed for one cycle. Afterwards the lock, the streak and the in-flight
  // read must all be gone.
  task automatic test_reset_flush();
    idle(3);
    for (int k = 0; k < 2; k++) begin
      tick();
      f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_lock = 1'b0;
      f_addr = 16'h0060; d_addr = 16'h0070;
    end
    tick();
    d_lock = 1'b1;
    #1;
    nCompared++;
    if ({a_d_gnt, b_d_gnt} !== 2'b11) begin
      nMismatched++;
      $display("[TB] FAIL flush_pre_grant: got A %b B %b want 1 1", a_d_gnt, b_d_gnt);
    end
    tick();
    reset = 1'b0;
    mem_rdata = 16'hFFFF;
    #1;
    nCompared++;
    if ({a_d_gnt, a_f_gnt, a_d_rvalid, a_d_rdata, a_mem_en, a_locked,
         b_d_gnt, b_f_gnt, b_mem_en, b_locked} !== 25'd0) begin
      nMismatched++;
      $display("[TB] FAIL flush_in_reset: got A gnt d%b f%b rv %b rd %h en %b lk %b B en %b lk %b want all 0",
               a_d_gnt, a_f_gnt, a_d_rvalid, a_d_rdata, a_mem_en, a_locked, b_mem_en, b_locked);
    end
    tick();
    reset = 1'b1;
    d_lock = 1'b0;
    #1;
    nCompared++;
    if ({a_d_gnt, a_f_gnt, a_locked} !== 3'b100) begin
      nMismatched++;
      $display("[TB] FAIL flush_after_release: got d %b f %b locked %b want 1 0 0",
               a_d_gnt, a_f_gnt, a_locked);
    end
    nCompared++;
    if ({a_d_rvalid, b_d_rvalid} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL flush_rvalid_0: got A %b B %b want 0 0", a_d_rvalid, b_d_rvalid);
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      f_req = 1'b0; d_req = 1'b0;
      #1;
      nCompared++;
      if ({b_d_rvalid, b_f_rvalid} !== 2'b00) begin
        nMismatched++;
        $display("[TB] FAIL flush_rvalid_B[+%0d]: got d %b f %b want 0 0", k, b_d_rvalid, b_f_rvalid);
      end
    end
  endtask

  // On dutB (MEM_LAT=3), reads alternate F(0x0001), D(0x0002), F, D.
  // Each return lands 3 cycles after its grant on the correct side only.
  task automatic test_interleave();
    logic fReq, dReq, expF, expD;
    logic [15:0] expAddr;
    idle(3);
    for (int i = 0; i < 7; i++) begin
      tick();
      fReq = (i < 4) && ((i % 2) == 0);
      dReq = (i < 4) && ((i % 2) == 1);
      f_req = fReq; f_addr = 16'h0001;
      d_req = dReq; d_addr = 16'h0002; d_we = 1'b0; d_lock = 1'b0;
      mem_rdata = (i < 3) ? 16'hDEAD : (((i % 2) == 1) ? 16'h1111 : 16'h2222);
      #1;
      expF = (i >= 3) && ((i % 2) == 1);
      expD = (i >= 3) && ((i % 2) == 0);
      expAddr = fReq ? 16'h0001 : (dReq ? 16'h0002 : 16'h0000);
      if (i < 4) begin
        nCompared++;
        if ({b_f_gnt, b_d_gnt, b_mem_addr} !== {fReq, dReq, expAddr}) begin
          nMismatched++;
          $display("[TB] FAIL interleave_grant[%0d]: got f %b d %b addr %h want f %b d %b addr %h",
                   i, b_f_gnt, b_d_gnt, b_mem_addr, fReq, dReq, expAddr);
        end
      end
      nCompared++;
      if ({b_f_rvalid, b_d_rvalid} !== {expF, expD}) begin
        nMismatched++;
        $display("[TB] FAIL interleave_rvalid[%0d]: got f %b d %b want f %b d %b",
                 i, b_f_rvalid, b_d_rvalid, expF, expD);
      end
      nCompared++;
      if ({b_f_rdata, b_d_rdata} !== {(expF ? 16'h1111 : 16'h0000), (expD ? 16'h2222 : 16'h0000)}) begin
        nMismatched++;
        $display("[TB] FAIL interleave_rdata[%0d]: got f %h d %h", i, b_f_rdata, b_d_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_back_to_back();
    test_write();
    test_lock();
    test_reset_flush();
    test_interleave();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
